// File: rtl/mc_bus_master.sv
// mc_bus_master -- processor-side bus master for the paged memory controllers.
//
// Takes one burst request at a time over a valid/ready handshake and plays it
// onto the multiplexed address/data bus: one address cycle, a turnaround cycle
// for reads, then a DATAPAYLOADSIZE-word data burst, then a one-cycle response.
//
// Optional feature macro: MC_BUS_MASTER_PAGE_CHECK_EN
//   defined   : requests to pages other than MEMPAGE1/MEMPAGE2 are rejected
//               (rsp_err=1, no bus cycle)
//   undefined : every request goes on the bus, rsp_err stays 0
//
// Ports
//   clk, resetH         clock, synchronous active-high reset
//   req_valid/req_ready request handshake (req_ready is combinational)
//   req_rw              1 = read, 0 = write
//   req_addr            burst start address (areg_t layout)
//   req_wdata           write payload, word i at [i*BUSWIDTH +: BUSWIDTH]
//   rsp_valid, rsp_err  one-cycle completion pulse and reject flag
//   rsp_rdata           read payload of the last completed read
//   bus_addr_valid      address cycle strobe
//   bus_rw              direction, driven in the address cycle only
//   bus_ad_out/_oe      master-driven address/data and its drive enable
//   bus_ad_in           value driven by the memory controller

package mcDefs;
  typedef struct packed {
    logic [3:0]  page;
    logic [11:0] loc;
  } areg_t;
  localparam logic [3:0] MEMPAGE1 = 4'h2;
  localparam logic [3:0] MEMPAGE2 = 4'hF;
endpackage

module mc_bus_master #(
  parameter int BUSWIDTH        = 16,
  parameter int DATAPAYLOADSIZE = 4
) (
  input  logic                                clk,
  input  logic                                resetH,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_rw,
  input  logic [BUSWIDTH-1:0]                 req_addr,
  input  logic [BUSWIDTH*DATAPAYLOADSIZE-1:0] req_wdata,
  output logic                                rsp_valid,
  output logic                                rsp_err,
  output logic [BUSWIDTH*DATAPAYLOADSIZE-1:0] rsp_rdata,
  output logic                                bus_addr_valid,
  output logic                                bus_rw,
  output logic [BUSWIDTH-1:0]                 bus_ad_out,
  output logic                                bus_ad_oe,
  input  logic [BUSWIDTH-1:0]                 bus_ad_in
);
  localparam int CNT_W = (DATAPAYLOADSIZE > 1) ? $clog2(DATAPAYLOADSIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATAPAYLOADSIZE - 1);

  typedef logic [DATAPAYLOADSIZE-1:0][BUSWIDTH-1:0] words_t;
  typedef enum logic [2:0] {IDLE, ADDR, TURN, DATA, RESP} state_e;

  state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic          rw_q, rw_d;
  mcDefs::areg_t addr_q, addr_d;
  words_t        wdata_q, wdata_d;
  logic          err_q, err_d;
  words_t        rbuf_q, rbuf_d;    // read words collected during the burst
  words_t        rdata_q, rdata_d;  // published only when a read completes
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic          addr_valid_q, addr_valid_d;
  logic          bus_rw_q, bus_rw_d;
  logic [BUSWIDTH-1:0] ad_out_q, ad_out_d;
  logic          oe_q, oe_d;
  logic          page_ok;

`ifdef MC_BUS_MASTER_PAGE_CHECK_EN
  // Page field of the areg_t layout sits in the top nibble.
  assign page_ok = (req_addr[15:12] == mcDefs::MEMPAGE1) ||
                   (req_addr[15:12] == mcDefs::MEMPAGE2);
`else
  assign page_ok = 1'b1;
`endif

  assign req_ready = (state_q == IDLE) && !resetH;

  // State and output registers
  always_ff @(posedge clk) begin
    if (resetH) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rbuf_q       <= '0;
      rdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      addr_valid_q <= 1'b0;
      bus_rw_q     <= 1'b0;
      ad_out_q     <= '0;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rbuf_q       <= rbuf_d;
      rdata_q      <= rdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      addr_valid_q <= addr_valid_d;
      bus_rw_q     <= bus_rw_d;
      ad_out_q     <= ad_out_d;
      oe_q         <= oe_d;
    end
  end

  // Next state, burst counter and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        rw_d    = req_rw;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        err_d   = !page_ok;
        state_d = page_ok ? ADDR : RESP;
      end
      ADDR: state_d = rw_q ? TURN : DATA;
      TURN: state_d = DATA;
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    addr_valid_d = 1'b0;
    bus_rw_d     = 1'b0;
    ad_out_d     = '0;
    oe_d         = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rbuf_d       = rbuf_q;
    rdata_d      = rdata_q;
    case (state_d)
      ADDR: begin
        addr_valid_d = 1'b1;
        bus_rw_d     = rw_d;
        ad_out_d     = addr_d;
        oe_d         = 1'b1;
      end
      DATA: if (!rw_d) begin
        oe_d     = 1'b1;
        ad_out_d = wdata_d[cnt_d];
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_d;
      end
      default: ;
    endcase
    // Read capture: sample at the end of each data cycle; the last word
    // publishes the whole burst so rsp_rdata never shows a partial read.
    if (state_q == DATA && rw_q) begin
      rbuf_d[cnt_q] = bus_ad_in;
      if (cnt_q == LAST) rdata_d = rbuf_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_rdata      = rdata_q;
  assign bus_addr_valid = addr_valid_q;
  assign bus_rw         = bus_rw_q;
  assign bus_ad_out     = ad_out_q;
  assign bus_ad_oe      = oe_q;

endmodule

// File: tb/tb_mc_bus_master.sv
// Bench for mc_bus_master: requests push their expected per-cycle bus/response
// picture into a queue; a negedge monitor pops and compares every cycle.
module tb_mc_bus_master;
  localparam int BW = 16;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          resetH = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rw = 1'b0;
  logic [BW-1:0] req_addr = '0;
  logic [BW*NW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_err;
  logic [BW*NW-1:0] rsp_rdata;
  logic          bus_addr_valid, bus_rw, bus_ad_oe;
  logic [BW-1:0] bus_ad_out;
  logic [BW-1:0] bus_ad_in = 16'hDEAD;

  mc_bus_master #(.BUSWIDTH(BW), .DATAPAYLOADSIZE(NW)) dut (
    .clk(clk), .resetH(resetH),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .bus_addr_valid(bus_addr_valid), .bus_rw(bus_rw),
    .bus_ad_out(bus_ad_out), .bus_ad_oe(bus_ad_oe), .bus_ad_in(bus_ad_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        av, rw, oe, rv, re;
    logic [15:0] ad;
    logic [63:0] rd;
  } snap_t;

  snap_t       sq[$];
  logic [15:0] sched[int];   // controller model: bus_ad_in per cycle
  logic [63:0] m_rdata = '0;
  logic [63:0] pred_rdata = '0;
  bit          mon_en = 1'b0;
  int          free_cyc = 0;

  function automatic void push(input int c, input logic av, input logic rw, input logic oe,
                               input logic [15:0] ad, input logic rv, input logic re,
                               input logic [63:0] rd);
    snap_t e;
    e.cyc = c; e.av = av; e.rw = rw; e.oe = oe; e.ad = ad;
    e.rv = rv; e.re = re; e.rd = rd;
    sq.push_back(e);
  endfunction

  always @(posedge clk) begin
    #1;
    bus_ad_in = sched.exists(cyc) ? sched[cyc] : 16'hDEAD;
  end

  always @(negedge clk) begin
    snap_t e;
    if (mon_en) begin
      e = '{default: '0};
      e.cyc = cyc;
      e.rd  = m_rdata;
      if (sq.size() > 0 && sq[0].cyc == cyc) e = sq.pop_front();
      m_rdata = e.rd;
      chk($sformatf("bus@%0d", cyc), 64'({bus_addr_valid, bus_rw, bus_ad_oe, bus_ad_out}),
          64'({e.av, e.rw, e.oe, e.ad}));
      chk($sformatf("rsp@%0d", cyc), 64'({rsp_valid, rsp_err}), 64'({e.rv, e.re}));
      chk($sformatf("rdata@%0d", cyc), rsp_rdata, e.rd);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic rw, input logic [15:0] addr, input logic [63:0] wd,
                        input logic [63:0] rdw, input bit keep);
    int a;
    bit rej;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
    a = (free_cyc > cyc) ? free_cyc : cyc;
    while (cyc < a) begin
      chk("hold_nrdy", 64'(req_ready), 64'd0);
      nxt();
    end
    chk("acc_rdy", 64'(req_ready), 64'd1);
`ifdef MC_BUS_MASTER_PAGE_CHECK_EN
    rej = !(addr[15:12] == 4'h2 || addr[15:12] == 4'hF);
`else
    rej = 1'b0;
`endif
    if (rej) begin
      push(a + 1, 0, 0, 0, 16'h0, 1, 1, pred_rdata);
      free_cyc = a + 2;
    end else begin
      push(a + 1, 1, rw, 1, addr, 0, 0, pred_rdata);
      if (rw) begin
        push(a + 2, 0, 0, 0, 16'h0, 0, 0, pred_rdata);
        for (int i = 0; i < NW; i++) begin
          sched[a + 3 + i] = rdw[16*i +: 16];
          push(a + 3 + i, 0, 0, 0, 16'h0, 0, 0, pred_rdata);
        end
        pred_rdata = rdw;
        push(a + 7, 0, 0, 0, 16'h0, 1, 0, pred_rdata);
        free_cyc = a + 8;
      end else begin
        for (int i = 0; i < NW; i++)
          push(a + 2 + i, 0, 0, 1, wd[16*i +: 16], 0, 0, pred_rdata);
        push(a + 6, 0, 0, 0, 16'h0, 1, 0, pred_rdata);
        free_cyc = a + 7;
      end
    end
    nxt();
    if (!keep) req_valid = 1'b0;
    // Scramble request fields mid-burst; the burst must not notice.
    req_rw = ~rw; req_addr = ~addr; req_wdata = ~wd;
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a;
    repeat (3) nxt();
    chk("por_bus", 64'({bus_addr_valid, bus_rw, bus_ad_oe, bus_ad_out}), 64'd0);
    chk("por_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    chk("por_rdata", rsp_rdata, 64'd0);
    chk("por_nrdy", 64'(req_ready), 64'd0);
    mon_en  = 1'b1;
    resetH  = 1'b0;
    #1;
    chk("por_rdy", 64'(req_ready), 64'd1);

    // Reset mid-write burst
    a = cyc;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h2ABC;
    req_wdata = 64'h0D0D_0C0C_0B0B_0A0A;
    chk("acc_rdy", 64'(req_ready), 64'd1);
    push(a + 1, 1, 0, 1, 16'h2ABC, 0, 0, 64'd0);
    push(a + 2, 0, 0, 1, 16'h0A0A, 0, 0, 64'd0);
    nxt(); req_valid = 1'b0;
    nxt(); resetH = 1'b1; #1;
    chk("rst_nrdy", 64'(req_ready), 64'd0);
    nxt();
    chk("rst_nrdy2", 64'(req_ready), 64'd0);
    nxt(); resetH = 1'b0; #1;
    chk("rel_rdy", 64'(req_ready), 64'd1);
    free_cyc = cyc;

    // Plain write, plain read
    do_req(1'b0, 16'h2010, 64'h4444_3333_2222_1111, 64'd0, 1'b0);
    nxt();
    do_req(1'b1, 16'hF0FC, 64'd0, 64'h00A3_00A2_00A1_00A0, 1'b0);
    // Bad page: rejected with the check, normal read without it
    do_req(1'b1, 16'h5000, 64'd0, 64'h00B3_00B2_00B1_00B0, 1'b0);
    // Back-to-back with req_valid held: write then read
    do_req(1'b0, 16'hF123, 64'h8765_4321_CAFE_BEEF, 64'd0, 1'b1);
    do_req(1'b1, 16'h2ABC, 64'hFFFF_EEEE_DDDD_CCCC, 64'h1234_5678_9ABC_DEF0, 1'b0);
    // Write after read keeps rsp_rdata
    do_req(1'b0, 16'h2F00, 64'h5555_6666_7777_8888, 64'd0, 1'b0);

    for (int i = 0; i < 30 && sq.size() > 0; i++) nxt();
    chk("drain", 64'(sq.size()), 64'd0);
    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
